// File: rtl/discrete_i2s_tx_if.sv
// Sample-in / serial-audio-out signal bundle for discrete_i2s_tx.
// The master is the sample producer plus the pin monitor; the slave is the transmitter.
interface discrete_i2s_tx_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               audio_clk_en;
  logic signed [15:0] sample_in;
  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic [LVL_W-1:0]   fill_level;
  logic               overflow;
  logic               underflow;

  modport master (
    output audio_clk_en, sample_in,
    input  bclk, lrclk, sdata, fill_level, overflow, underflow
  );

  modport slave (
    input  audio_clk_en, sample_in,
    output bclk, lrclk, sdata, fill_level, overflow, underflow
  );
endinterface

// File: rtl/discrete_i2s_tx.sv
// Buffers mono 16-bit samples in a small FIFO and sends each one MSB first,
// left-justified, on both channels of a 32-bit-per-frame serial audio stream.
module discrete_i2s_tx #(
  parameter int BCLK_DIV   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  discrete_i2s_tx_if.slave  snd_if
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [15:0]      mem [FIFO_DEPTH];

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [15:0]      last_q, last_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             pop_q, pop_d;
  logic             uflow_pend_q, uflow_pend_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic tc, fall_evt, frame_evt, empty, full;
  logic pop_decide, early_pop, popping, wr_en;

  // The frame-start pop is decided and its data loaded at the falling event,
  // but the FIFO bookkeeping retires one cycle later (pop_q). Only when a write
  // hits a full FIFO on the decision cycle is the pop retired immediately to
  // make room.
  always_comb begin
    tc         = (div_q == DIV_W'(BCLK_DIV - 1));
    fall_evt   = tc && bclk_q;
    frame_evt  = fall_evt && (bit_cnt_q == 5'd31);
    empty      = (count_q == '0);
    full       = (count_q == LVL_W'(FIFO_DEPTH));
    pop_decide = frame_evt && !empty;
    early_pop  = pop_decide && snd_if.audio_clk_en && full;
    popping    = pop_q || early_pop;
    wr_en      = snd_if.audio_clk_en && (!full || popping);

    div_d        = tc ? '0 : div_q + DIV_W'(1);
    bclk_d       = tc ? ~bclk_q : bclk_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    shreg_d      = shreg_q;
    last_d       = last_q;
    pop_d        = pop_decide && !early_pop;
    uflow_pend_d = frame_evt && empty;
    underflow_d  = uflow_pend_q;
    overflow_d   = snd_if.audio_clk_en && full && !popping;
    wr_ptr_d     = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = popping ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + LVL_W'(wr_en) - LVL_W'(popping);

    if (fall_evt) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      lrclk_d   = bit_cnt_d[4];
      if (frame_evt) begin
        if (!empty) last_d = mem[rd_ptr_q];
        shreg_d = last_d;
      end else if (bit_cnt_q == 5'd15) begin
        shreg_d = last_q;
      end else begin
        shreg_d = {shreg_q[14:0], 1'b0};
      end
      sdata_d = shreg_d[15];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      bclk_q       <= 1'b0;
      bit_cnt_q    <= 5'd31;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      shreg_q      <= '0;
      last_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pop_q        <= 1'b0;
      uflow_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      div_q        <= div_d;
      bclk_q       <= bclk_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      shreg_q      <= shreg_d;
      last_q       <= last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pop_q        <= pop_d;
      uflow_pend_q <= uflow_pend_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_ptr_q] <= snd_if.sample_in;
  end

  assign snd_if.bclk       = bclk_q;
  assign snd_if.lrclk      = lrclk_q;
  assign snd_if.sdata      = sdata_q;
  assign snd_if.fill_level = count_q;
  assign snd_if.overflow   = overflow_q;
  assign snd_if.underflow  = underflow_q;
endmodule

// File: tb/tb_discrete_i2s_tx.sv
// Directed bench for discrete_i2s_tx with BCLK_DIV=2, FIFO_DEPTH=4.
// cyc counts clk cycles from reset release; outputs are sampled 1ns after each edge.
module tb_discrete_i2s_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   cyc = 0;

  discrete_i2s_tx_if #(.FIFO_DEPTH(4)) bus ();

  discrete_i2s_tx #(.BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .snd_if (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic advanceTo(input int target);
    while (cyc < target) step();
  endtask

  // Drive a strobe during the current cycle, then move to the next one.
  task automatic applyStimulus(input logic en, input logic [15:0] s);
    bus.audio_clk_en = en;
    bus.sample_in    = s;
    step();
    bus.audio_clk_en = 1'b0;
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    bus.audio_clk_en = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    cyc = 0;
  endtask

  // Collects the 32 bits seen on the bclk rises of the frame starting at 'start'.
  task automatic captureFrame(input int start, output logic [15:0] l,
                              output logic [15:0] r, output int bad);
    l = '0; r = '0; bad = 0;
    for (int k = 0; k < 32; k++) begin
      advanceTo(start + 2 + 4 * k);
      if (bus.bclk !== 1'b1 || bus.lrclk !== (k >= 16)) bad++;
      if (k < 16) l = {l[14:0], bus.sdata};
      else        r = {r[14:0], bus.sdata};
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.audio_clk_en = 1'b0;
    bus.sample_in = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.audio_clk_en = (i % 2 == 0);
      bus.sample_in = 16'h1234;
      step();
      nCompared++;
      if ({bus.bclk, bus.lrclk, bus.sdata} !== 3'b000) begin
        nMismatched++;
        $display("[TB] FAIL reset_pins got=%b want=000", {bus.bclk, bus.lrclk, bus.sdata});
      end
      nCompared++;
      if (bus.fill_level !== 3'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset_fill got=%0d want=0", bus.fill_level);
      end
      nCompared++;
      if ({bus.overflow, bus.underflow} !== 2'b00) begin
        nMismatched++;
        $display("[TB] FAIL reset_flags got=%b want=00", {bus.overflow, bus.underflow});
      end
    end
    bus.audio_clk_en = 1'b0;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_first_frame();
    logic [15:0] l, r;
    int bad;
    applyStimulus(1'b1, 16'h8001);
    nCompared++;
    if (bus.fill_level !== 3'd1) begin
      nMismatched++;
      $display("[TB] FAIL ff_fill_c1 got=%0d want=1", bus.fill_level);
    end
    advanceTo(2);
    nCompared++;
    if (bus.bclk !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ff_bclk_rise got=%b want=1", bus.bclk);
    end
    advanceTo(4);
    nCompared++;
    if ({bus.bclk, bus.lrclk, bus.sdata} !== 3'b001) begin
      nMismatched++;
      $display("[TB] FAIL ff_frame_start got=%b want=001", {bus.bclk, bus.lrclk, bus.sdata});
    end
    advanceTo(5);
    nCompared++;
    if (bus.fill_level !== 3'd0 || bus.underflow !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ff_c5 got fill=%0d uf=%b want fill=0 uf=0", bus.fill_level, bus.underflow);
    end
    captureFrame(4, l, r, bad);
    nCompared++;
    if (l !== 16'h8001 || r !== 16'h8001 || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL ff_bits got l=%h r=%h bad=%0d want l=8001 r=8001 bad=0", l, r, bad);
    end
  endtask

  task automatic test_underflow_repeat();
    logic [15:0] l, r;
    int bad, s;
    for (int f = 1; f <= 2; f++) begin
      s = 4 + 128 * f;
      advanceTo(s);
      nCompared++;
      if (bus.underflow !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL ur_early frame=%0d got=%b want=0", f, bus.underflow);
      end
      advanceTo(s + 1);
      nCompared++;
      if (bus.underflow !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL ur_pulse frame=%0d got=%b want=1", f, bus.underflow);
      end
      advanceTo(s + 2);
      nCompared++;
      if (bus.underflow !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL ur_len frame=%0d got=%b want=0", f, bus.underflow);
      end
      captureFrame(s, l, r, bad);
      nCompared++;
      if (l !== 16'h8001 || r !== 16'h8001 || bad !== 0) begin
        nMismatched++;
        $display("[TB] FAIL ur_bits frame=%0d got l=%h r=%h bad=%0d want 8001", f, l, r, bad);
      end
    end
    applyReset(2);
    advanceTo(4);
    nCompared++;
    if (bus.underflow !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ur_nowr_c4 got=%b want=0", bus.underflow);
    end
    advanceTo(5);
    nCompared++;
    if (bus.underflow !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ur_nowr_c5 got=%b want=1", bus.underflow);
    end
    captureFrame(4, l, r, bad);
    nCompared++;
    if (l !== 16'h0000 || r !== 16'h0000 || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL ur_nowr_bits got l=%h r=%h bad=%0d want 0000", l, r, bad);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] l, r, exp;
    int bad, s;
    applyReset(2);
    advanceTo(10);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 16'(i));
      if (i == 4) begin
        nCompared++;
        if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL ov_c14 got fill=%0d ov=%b want fill=4 ov=0", bus.fill_level, bus.overflow);
        end
      end
    end
    nCompared++;
    if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ov_c15 got fill=%0d ov=%b want fill=4 ov=1", bus.fill_level, bus.overflow);
    end
    step();
    nCompared++;
    if (bus.overflow !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ov_c16 got=%b want=0", bus.overflow);
    end
    for (int f = 1; f <= 5; f++) begin
      s = 4 + 128 * f;
      exp = (f < 5) ? 16'(f) : 16'd4;
      advanceTo(s + 1);
      nCompared++;
      if (bus.underflow !== (f == 5)) begin
        nMismatched++;
        $display("[TB] FAIL ov_uf frame=%0d got=%b want=%b", f, bus.underflow, (f == 5));
      end
      if (f == 1) begin
        nCompared++;
        if (bus.fill_level !== 3'd3) begin
          nMismatched++;
          $display("[TB] FAIL ov_fill_pop got=%0d want=3", bus.fill_level);
        end
      end
      captureFrame(s, l, r, bad);
      nCompared++;
      if (l !== exp || r !== exp || bad !== 0) begin
        nMismatched++;
        $display("[TB] FAIL ov_bits frame=%0d got l=%h r=%h bad=%0d want %h", f, l, r, bad, exp);
      end
    end
  endtask

  task automatic test_full_with_pop();
    logic [15:0] l, r;
    int bad;
    applyReset(2);
    advanceTo(10);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 16'hA000 + 16'(i));
    nCompared++;
    if (bus.fill_level !== 3'd4) begin
      nMismatched++;
      $display("[TB] FAIL fp_fill_full got=%0d want=4", bus.fill_level);
    end
    advanceTo(132);
    applyStimulus(1'b1, 16'hBEEF);
    nCompared++;
    if (bus.fill_level !== 3'd4 || bus.overflow !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL fp_c133 got fill=%0d ov=%b want fill=4 ov=0", bus.fill_level, bus.overflow);
    end
    captureFrame(132, l, r, bad);
    nCompared++;
    if (l !== 16'hA001 || r !== 16'hA001 || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL fp_bits1 got l=%h r=%h bad=%0d want A001", l, r, bad);
    end
    captureFrame(260, l, r, bad);
    nCompared++;
    if (l !== 16'hA002 || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL fp_bits2 got l=%h bad=%0d want A002", l, bad);
    end
    advanceTo(645);
    nCompared++;
    if (bus.underflow !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL fp_uf got=%b want=0", bus.underflow);
    end
    captureFrame(644, l, r, bad);
    nCompared++;
    if (l !== 16'hBEEF || r !== 16'hBEEF || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL fp_bits5 got l=%h r=%h bad=%0d want BEEF", l, r, bad);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] l, r;
    int bad;
    applyReset(2);
    applyStimulus(1'b1, 16'h5A5A);
    advanceTo(40);
    applyStimulus(1'b1, 16'h1357);
    advanceTo(84);
    nCompared++;
    if (bus.lrclk !== 1'b1 || bus.sdata !== 1'b1 || bus.fill_level !== 3'd1) begin
      nMismatched++;
      $display("[TB] FAIL rm_before got lr=%b sd=%b fill=%0d want lr=1 sd=1 fill=1",
               bus.lrclk, bus.sdata, bus.fill_level);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc = 0;
    nCompared++;
    if ({bus.bclk, bus.lrclk, bus.sdata, bus.overflow, bus.underflow} !== 5'b0 ||
        bus.fill_level !== 3'd0) begin
      nMismatched++;
      $display("[TB] FAIL rm_after got pins=%b fill=%0d want pins=00000 fill=0",
               {bus.bclk, bus.lrclk, bus.sdata, bus.overflow, bus.underflow}, bus.fill_level);
    end
    advanceTo(3);
    nCompared++;
    if (bus.bclk !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL rm_bclk_c3 got=%b want=1", bus.bclk);
    end
    advanceTo(4);
    nCompared++;
    if (bus.bclk !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL rm_bclk_c4 got=%b want=0", bus.bclk);
    end
    advanceTo(5);
    nCompared++;
    if (bus.underflow !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL rm_uf got=%b want=1", bus.underflow);
    end
    captureFrame(4, l, r, bad);
    nCompared++;
    if (l !== 16'h0000 || r !== 16'h0000 || bad !== 0) begin
      nMismatched++;
      $display("[TB] FAIL rm_bits got l=%h r=%h bad=%0d want 0000", l, r, bad);
    end
  endtask

  initial begin
    bus.audio_clk_en = 1'b0;
    bus.sample_in    = '0;
    test_reset();
    test_first_frame();
    test_underflow_repeat();
    test_overflow();
    test_full_with_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
